sdram_ch2_reqq: RTL and testbench

- Request queue that sits directly upstream of the SDRAM controller's 32-bit channel (ch2).
- Accepts 32-bit read/write requests from a client with a valid/ready handshake and buffers them in a FIFO.
- Issues them to the controller one at a time as single-cycle request pulses, waiting for each ready pulse before issuing the next.
- Returns read data to the client as a one-cycle valid strobe, in request order.

---
 rtl/sdram_ch2_reqq.sv | 142 ++++++++++++++
 tb/tb_sdram_ch2_reqq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ch2_reqq.sv
// Request FIFO in front of SDRAM ch2: one request in flight, sd_req pulses one cycle after pop; rd_valid one cycle after sd_ready.
// Backpressure: in_ready drops only when all DEPTH entries are occupied; the in-flight request does not count.
module sdram_ch2_reqq #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [26:0]   in_addr,
  input  logic [31:0]   in_din,
  input  logic          in_rnw,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic [AW:0]   level,
  output logic          busy,
  output logic [26:0]   sd_addr,
  output logic [31:0]   sd_din,
  output logic          sd_rnw,
  output logic          sd_req,
  input  logic          sd_ready,
  input  logic [31:0]   sd_dout
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // Entry layout: {addr[26:0], din[31:0], rnw}
  logic [59:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  state_t        state_q, state_d;

  logic [26:0]   sd_addr_q, sd_addr_d;
  logic [31:0]   sd_din_q, sd_din_d;
  logic          sd_rnw_q, sd_rnw_d;
  logic          sd_req_q, sd_req_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          full, empty, push, pop;
  logic [59:0]   head;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    sd_addr_d  = sd_addr_q;
    sd_din_d   = sd_din_q;
    sd_rnw_d   = sd_rnw_q;
    sd_req_d   = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          sd_req_d = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (sd_ready) begin
          if (sd_rnw_q) begin
            rd_data_d  = sd_dout;
            rd_valid_d = 1'b1;
          end
          if (!empty) begin
            pop      = 1'b1;
            sd_req_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      sd_addr_d = head[59:33];
      sd_din_d  = head[32:1];
      sd_rnw_d  = head[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sd_addr_q  <= '0;
      sd_din_q   <= '0;
      sd_rnw_q   <= 1'b0;
      sd_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      sd_rnw_q   <= sd_rnw_d;
      sd_req_q   <= sd_req_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Controller needs 16-bit aligned addresses, so bit 0 is dropped on entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_addr[26:1], 1'b0, in_din, in_rnw};
  end

  assign in_ready = !full;
  assign level    = level_q;
  assign busy     = (state_q == WAIT) || !empty;
  assign sd_addr  = sd_addr_q;
  assign sd_din   = sd_din_q;
  assign sd_rnw   = sd_rnw_q;
  assign sd_req   = sd_req_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sdram_ch2_reqq.sv
module tb_sdram_ch2_reqq;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_addr = '0;
  logic [31:0] in_din = '0;
  logic        in_rnw = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  level;
  logic        busy;
  logic [26:0] sd_addr;
  logic [31:0] sd_din;
  logic        sd_rnw;
  logic        sd_req;
  logic        sd_ready = 1'b0;
  logic [31:0] sd_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_ch2_reqq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_din(in_din), .in_rnw(in_rnw),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .busy(busy),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_rnw(sd_rnw), .sd_req(sd_req),
    .sd_ready(sd_ready), .sd_dout(sd_dout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Directed vectors: inputs applied for one cycle, outputs expected after that edge.
  typedef struct {
    logic        iv;
    logic [26:0] ia;
    logic [31:0] id;
    logic        ir;
    logic        rdy;
    logic [31:0] dout;
    logic        e_req;
    logic [26:0] e_addr;
    logic [31:0] e_din;
    logic        e_rnw;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [3:0]  e_lvl;
    logic        e_busy;
    logic        e_inrdy;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [26:0] ia, input logic [31:0] id,
                              input logic ir, input logic rdy, input logic [31:0] dout,
                              input logic e_req, input logic [26:0] e_addr, input logic [31:0] e_din,
                              input logic e_rnw, input logic e_rv, input logic [31:0] e_rd,
                              input logic [3:0] e_lvl, input logic e_busy, input logic e_inrdy);
    vec_t v;
    v.iv = iv; v.ia = ia; v.id = id; v.ir = ir; v.rdy = rdy; v.dout = dout;
    v.e_req = e_req; v.e_addr = e_addr; v.e_din = e_din; v.e_rnw = e_rnw;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_lvl = e_lvl; v.e_busy = e_busy; v.e_inrdy = e_inrdy;
    return v;
  endfunction

  // Reference model: FIFO as a queue, plus the one request currently at the controller.
  typedef struct packed {
    logic [26:0] addr;
    logic [31:0] din;
    logic        rnw;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_cur;
  bit          m_out;
  logic        m_req, m_rv;
  logic [31:0] m_rd;
  int          l3_hits = 0;

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; sd_ready = 1'b0;
    mq.delete(); m_out = 0; m_cur = '0; m_rd = '0; m_req = 1'b0; m_rv = 1'b0;
    #1;
    chk("reset_cmd", {sd_req, sd_addr, sd_din, sd_rnw}, '0);
    chk("reset_rsp", {rd_valid, rd_data, level, busy, in_ready}, {1'b0, 32'h0, 4'd0, 1'b0, 1'b1});
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic mstep(input logic iv, input logic [26:0] a, input logic [31:0] d, input logic r,
                       input logic rdy, input logic [31:0] dout);
    ent_t e;
    bit   acc;
    int   n0;
    in_valid = iv; in_addr = a; in_din = d; in_rnw = r; sd_ready = rdy; sd_dout = dout;
    n0 = mq.size();
    acc = iv && (n0 < DEPTH);
    m_req = 1'b0; m_rv = 1'b0;
    if (m_out && rdy) begin
      if (m_cur.rnw) begin m_rv = 1'b1; m_rd = dout; end
      if (n0 > 0) begin m_cur = mq.pop_front(); m_req = 1'b1; end
      else m_out = 0;
    end else if (!m_out && n0 > 0) begin
      m_cur = mq.pop_front(); m_req = 1'b1; m_out = 1;
    end
    if (acc) begin
      e.addr = {a[26:1], 1'b0}; e.din = d; e.rnw = r;
      mq.push_back(e);
    end
    if (acc && m_req && n0 == 3) l3_hits++;
    @(posedge clk);
    @(negedge clk);
    chk("model_req", {63'h0, sd_req}, {63'h0, m_req});
    chk("model_cmd", {sd_addr, sd_din, sd_rnw}, m_cur);
    chk("model_rsp", {rd_valid, rd_data, level, busy, in_ready},
        {m_rv, m_rd, 4'(mq.size()), (m_out || mq.size() > 0), (mq.size() < DEPTH)});
  endtask

  task automatic idle(input logic rdy);
    mstep(1'b0, '0, '0, 1'b0, rdy, $urandom);
  endtask

  initial begin
    vec_t tbl[15];
    tbl[0]  = mk(1, 27'h0000100, 32'hCAFEBABE, 0, 0, 32'h0,       0, 27'h0, 32'h0, 0, 0, 32'h0, 1, 1, 1);
    tbl[1]  = mk(0, 27'h0, 32'h0, 0, 0, 32'h0,                    1, 27'h0000100, 32'hCAFEBABE, 0, 0, 32'h0, 0, 1, 1);
    for (int i = 2; i <= 7; i++)
      tbl[i] = mk(0, 27'h0, 32'h0, 0, 0, 32'h0,                   0, 27'h0000100, 32'hCAFEBABE, 0, 0, 32'h0, 0, 1, 1);
    tbl[8]  = mk(0, 27'h0, 32'h0, 0, 1, 32'h55AA55AA,             0, 27'h0000100, 32'hCAFEBABE, 0, 0, 32'h0, 0, 0, 1);
    tbl[9]  = mk(0, 27'h0, 32'h0, 0, 0, 32'h0,                    0, 27'h0000100, 32'hCAFEBABE, 0, 0, 32'h0, 0, 0, 1);
    tbl[10] = mk(1, 27'h4000003, 32'hDEAD0001, 1, 0, 32'h0,       0, 27'h0000100, 32'hCAFEBABE, 0, 0, 32'h0, 1, 1, 1);
    tbl[11] = mk(0, 27'h0, 32'h0, 0, 0, 32'h0,                    1, 27'h4000002, 32'hDEAD0001, 1, 0, 32'h0, 0, 1, 1);
    tbl[12] = mk(0, 27'h0, 32'h0, 0, 0, 32'h0,                    0, 27'h4000002, 32'hDEAD0001, 1, 0, 32'h0, 0, 1, 1);
    tbl[13] = mk(0, 27'h0, 32'h0, 0, 1, 32'h12345678,             0, 27'h4000002, 32'hDEAD0001, 1, 1, 32'h12345678, 0, 0, 1);
    tbl[14] = mk(0, 27'h0, 32'h0, 0, 0, 32'h0,                    0, 27'h4000002, 32'hDEAD0001, 1, 0, 32'h12345678, 0, 0, 1);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].iv; in_addr = tbl[i].ia; in_din = tbl[i].id; in_rnw = tbl[i].ir;
      sd_ready = tbl[i].rdy; sd_dout = tbl[i].dout;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_cmd", i), {sd_req, sd_addr, sd_din, sd_rnw},
          {tbl[i].e_req, tbl[i].e_addr, tbl[i].e_din, tbl[i].e_rnw});
      chk($sformatf("vec%0d_rsp", i), {rd_valid, rd_data, level, busy, in_ready},
          {tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_lvl, tbl[i].e_busy, tbl[i].e_inrdy});
    end

    // Fill with ready withheld: one entry goes to the controller, the rest back up.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      mstep(1'b1, 27'h1000 + 27'(k * 16), 32'hA0000000 + 32'(k), k[0], 1'b0, '0);
      if (k == 7) chk("fill_lvl7", {59'h0, level, in_ready}, {59'h0, 4'd7, 1'b1});
      if (k == 8) chk("fill_full", {59'h0, level, in_ready}, {59'h0, 4'd8, 1'b0});
      if (k == 9) chk("fill_reject", {59'h0, level, in_ready}, {59'h0, 4'd8, 1'b0});
    end
    for (int j = 0; j < 9; j++) begin
      idle(1'b1);
      if (j < 8) chk("drain_order", {37'h0, sd_req, sd_addr}, {37'h0, 1'b1, 27'h1000 + 27'((j + 1) * 16)});
      idle(1'b0);
    end
    chk("drain_idle", {63'h0, busy}, 64'h0);

    // Simultaneous push and pop at level 3.
    do_reset();
    for (int k = 0; k < 4; k++) mstep(1'b1, 27'($urandom), $urandom, 1'b0, 1'b0, '0);
    mstep(1'b1, 27'($urandom), $urandom, 1'b1, 1'b1, $urandom);
    chk("l3_level", {60'h0, level}, 64'd3);
    for (int k = 0; k < 12; k++) idle(1'b1);

    // Reset while a request is outstanding with 4 entries queued; then a stale ready.
    do_reset();
    for (int k = 0; k < 5; k++) mstep(1'b1, 27'h0200000 + 27'(k * 4), $urandom, 1'b1, 1'b0, '0);
    chk("pre_rst_lvl", {59'h0, level, busy}, {59'h0, 4'd4, 1'b1});
    #2;
    do_reset();
    idle(1'b0);
    idle(1'b1);
    chk("stale_rdy", {62'h0, rd_valid, sd_req}, 64'h0);
    mstep(1'b1, 27'h4000ABD, 32'h0BADF00D, 1'b1, 1'b0, '0);
    idle(1'b0);
    idle(1'b0);
    mstep(1'b0, '0, '0, 1'b0, 1'b1, 32'hFEEDFACE);
    chk("post_rst_read", {31'h0, rd_valid, rd_data}, {31'h0, 1'b1, 32'hFEEDFACE});

    // Randomized mixed traffic against the model.
    for (int c = 0; c < 400; c++)
      mstep($urandom_range(0, 1) == 1, 27'($urandom), $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom);
    for (int c = 0; c < 24; c++) idle(1'b1);
    chk("rand_drained", {63'h0, busy}, 64'h0);

    // Ready held through the request cycle and two idle cycles afterwards.
    mstep(1'b1, 27'h0000040, 32'h11112222, 1'b0, 1'b0, '0);
    idle(1'b0);
    chk("hold_req", {63'h0, sd_req}, 64'h1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("hold_idle", {62'h0, busy, rd_valid}, 64'h0);

    sd_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
